// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single regfile write port between ALU (port 0) and load (port 1) writeback.
// Optional REGFILE_WB_FWD_EN adds write-to-read forwarding of the in-flight registered write.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] reg0,
  input  logic [DATA_WIDTH-1:0] data0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] reg1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  ack1,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  grant_id
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [DATA_WIDTH-1:0] rf_ReadData1,
  input  logic [DATA_WIDTH-1:0] rf_ReadData2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic                  prio_reg;
  logic                  sel;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] sel_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_live;

  // With both requesting the pointer decides; otherwise whichever port is asking wins.
  always_comb begin
    sel      = (req0 && req1) ? prio_reg : req1;
    grant    = reset_n && !stall && (req0 || req1);
    sel_idx  = sel ? reg1 : reg0;
    sel_data = sel ? data1 : data0;
    sel_live = (sel_idx != ZERO_IDX);
  end

  assign ack0 = grant && !sel;
  assign ack1 = grant && sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_reg      <= 1'b0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      grant_id      <= 1'b0;
    end else begin
      RegWrite <= grant && sel_live;
      if (grant) begin
        prio_reg <= ~sel;
        // Zero-register writes are consumed but leave the output fields untouched.
        if (sel_live) begin
          WriteRegister <= sel_idx;
          WriteData     <= sel_data;
          grant_id      <= sel;
        end
      end
    end
  end

`ifdef REGFILE_WB_FWD_EN
  assign ReadData1 = (RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_IDX))
                     ? WriteData : rf_ReadData1;
  assign ReadData2 = (RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_IDX))
                     ? WriteData : rf_ReadData2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter, checked against a rule-level model
// and a shadow register file built from acceptances.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        req0, req1;
  logic [4:0]  reg0, reg1;
  logic [63:0] data0, data1;
  logic        ack0, ack1;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic        grant_id;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [63:0] rf_ReadData1, rf_ReadData2, ReadData1, ReadData2;
`endif

  regfile_write_arbiter dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .req0(req0), .reg0(reg0), .data0(data0), .ack0(ack0),
    .req1(req1), .reg1(reg1), .data1(data1), .ack1(ack1),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .grant_id(grant_id)
`ifdef REGFILE_WB_FWD_EN
    , .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .rf_ReadData1(rf_ReadData1), .rf_ReadData2(rf_ReadData2),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus intent for the next cycle
  logic        s, r0, r1;
  logic [4:0]  a0, a1;
  logic [63:0] d0, d1;

  // Reference model: priority pointer, expected output registers, shadow regfiles
  bit          m_prio;
  bit          m_we;
  logic [4:0]  m_wr;
  logic [63:0] m_wd;
  bit          m_gid;
  logic [63:0] m_rf [32];
  logic [63:0] d_rf [32];
  bit          last_ack0, last_ack1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_ack0"}, 64'(ack0), 64'd0);
    chk({tag, "_ack1"}, 64'(ack1), 64'd0);
    chk({tag, "_RegWrite"}, 64'(RegWrite), 64'd0);
    chk({tag, "_WriteRegister"}, 64'(WriteRegister), 64'd0);
    chk({tag, "_WriteData"}, WriteData, 64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
  endtask

`ifdef REGFILE_WB_FWD_EN
  function automatic logic [63:0] fwd(input logic [4:0] rr, input logic [63:0] rfd);
    return (m_we && m_wr == rr && rr != 5'd31) ? m_wd : rfd;
  endfunction
`endif

  // One clock: drive at negedge, check outputs and acks, then advance the model across the posedge.
  task automatic cycle();
    bit ea0, ea1, k;
    @(negedge clk);
    stall = s; req0 = r0; req1 = r1; reg0 = a0; reg1 = a1; data0 = d0; data1 = d1;
`ifdef REGFILE_WB_FWD_EN
    ReadRegister1 = ($urandom_range(0, 1) == 1) ? m_wr : 5'($urandom_range(0, 31));
    ReadRegister2 = ($urandom_range(0, 3) == 0) ? m_wr : 5'($urandom_range(0, 31));
    rf_ReadData1  = {$urandom, $urandom};
    rf_ReadData2  = {$urandom, $urandom};
`endif
    #1;
    chk("RegWrite", 64'(RegWrite), 64'(m_we));
    chk("WriteRegister", 64'(WriteRegister), 64'(m_wr));
    chk("WriteData", WriteData, m_wd);
    chk("grant_id", 64'(grant_id), 64'(m_gid));
`ifdef REGFILE_WB_FWD_EN
    chk("ReadData1", ReadData1, fwd(ReadRegister1, rf_ReadData1));
    chk("ReadData2", ReadData2, fwd(ReadRegister2, rf_ReadData2));
`endif
    if (m_we) m_rf[m_wr] = m_wd;
    if (RegWrite === 1'b1) d_rf[WriteRegister] = WriteData;

    ea0 = 1'b0; ea1 = 1'b0;
    if (!s) begin
      if (r0 && r1) begin
        if (m_prio) ea1 = 1'b1; else ea0 = 1'b1;
      end else begin
        ea0 = r0; ea1 = r1;
      end
    end
    chk("ack0", 64'(ack0), 64'(ea0));
    chk("ack1", 64'(ack1), 64'(ea1));
    last_ack0 = ea0; last_ack1 = ea1;

    m_we = 1'b0;
    if (ea0 || ea1) begin
      k = ea1;
      m_prio = ~k;
      if ((k ? a1 : a0) != 5'd31) begin
        m_we  = 1'b1;
        m_wr  = k ? a1 : a0;
        m_wd  = k ? d1 : d0;
        m_gid = k;
      end
    end
  endtask

  task automatic model_reset();
    m_prio = 1'b0; m_we = 1'b0; m_wr = '0; m_wd = '0; m_gid = 1'b0;
  endtask

  // Asynchronous reset between edges; whatever write was registered is lost.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero_state("midreset");
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
    model_reset();
    reset_n = 1'b0;
    s = 0; r0 = 1; r1 = 1; a0 = 5'd1; a1 = 5'd2; d0 = 64'h11; d1 = 64'h22;
    stall = s; req0 = r0; req1 = r1; reg0 = a0; reg1 = a1; data0 = d0; data1 = d1;
`ifdef REGFILE_WB_FWD_EN
    ReadRegister1 = '0; ReadRegister2 = '0; rf_ReadData1 = '0; rf_ReadData2 = '0;
`endif
    #11 chk_zero_state("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle();                       // both requesting, prio=0 -> port 0
    r0 = 0; r1 = 0; cycle(); cycle();

    // Single port write
    r0 = 1; a0 = 5'd5; d0 = 64'h0000010204080001; cycle();
    r0 = 0; cycle(); cycle();

    // Contention: both held for 4 cycles, fresh data after every ack
    r0 = 1; r1 = 1;
    for (int i = 0; i < 4; i++) begin
      a0 = 5'(10 + i); d0 = 64'h100 + 64'(i);
      a1 = 5'(20 + i); d1 = 64'h200 + 64'(i);
      cycle();
    end
    r0 = 0; r1 = 0; cycle(); cycle();

    // Zero-register request then contention
    r1 = 1; a1 = 5'd31; d1 = 64'hA0; cycle();
    r0 = 1; a0 = 5'd3; d0 = 64'h33; a1 = 5'd4; d1 = 64'h44; cycle();
    r0 = 0; cycle();
    r1 = 0; cycle(); cycle();

    // Stall blocks grants but not a write already registered
    r0 = 1; a0 = 5'd6; d0 = 64'h66; cycle();
    s = 1; a0 = 5'd7; d0 = 64'h77;
    for (int i = 0; i < 3; i++) cycle();
    s = 0; cycle();
    r0 = 0; cycle(); cycle();

    // Reset mid-operation with both requesters pending
    r0 = 1; r1 = 1; a0 = 5'd8; d0 = 64'h88; a1 = 5'd9; d1 = 64'h99; cycle();
    a0 = 5'd12; d0 = 64'hC0; a1 = 5'd13; d1 = 64'hD0;
    do_reset();
    cycle(); cycle();
    r0 = 0; r1 = 0; cycle();

    // Randomized traffic with requesters that hold until acked
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 4) == 0);
      cycle();
      if (last_ack0 || !r0) begin
        r0 = ($urandom_range(0, 3) != 0);
        a0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d0 = {$urandom, $urandom};
      end
      if (last_ack1 || !r1) begin
        r1 = ($urandom_range(0, 2) != 0);
        a1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d1 = {$urandom, $urandom};
      end
      if (n == 200) do_reset();
    end
    r0 = 0; r1 = 0; s = 0; cycle(); cycle();

    // End-state regfile contents, including ordering of same-register writes
    for (int i = 0; i < 32; i++) chk($sformatf("regfile_x%0d", i), d_rf[i], m_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
